// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32I pipeline control logic.
//   - Opcode constants for the instruction classes the hazard logic inspects.
//   - Bit positions of the rd/rs1/rs2/opcode fields.
//   - Hazard sequencer state encoding.
//   - Helpers that tell whether an instruction reads rs1 / rs2.
// ---------------------------------------------------------------------------
package core_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // U-type and JAL carry immediate bits where rs1 would sit.
    function automatic logic usesRs1(input logic [6:0] opcode);
        return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    endfunction

    // Only R-type, stores and branches read a second source register.
    function automatic logic usesRs2(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// ---------------------------------------------------------------------------
// hazard_decode
// Purely combinational load-use detector. Flags when the EX instruction is a
// load whose destination is read by the ID instruction, which forwarding
// cannot cover because the load data is not available until MEM completes.
// Ports:
//   i_inst_id     instruction in ID
//   i_inst_ex     instruction in EX
//   i_memread_ex  EX instruction is a load
//   o_load_use    ID depends on the EX load result (x0 never counts)
// ---------------------------------------------------------------------------
module hazard_decode
    import core_pkg::*;
(
    input  logic [31:0] i_inst_id,
    input  logic [31:0] i_inst_ex,
    input  logic        i_memread_ex,
    output logic        o_load_use
);

    logic [4:0] w_rd_ex;
    logic [4:0] w_rs1_id;
    logic [4:0] w_rs2_id;
    logic [6:0] w_opc_id;
    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_unused_bits;

    assign w_rd_ex  = i_inst_ex[RD_MSB:RD_LSB];
    assign w_rs1_id = i_inst_id[RS1_MSB:RS1_LSB];
    assign w_rs2_id = i_inst_id[RS2_MSB:RS2_LSB];
    assign w_opc_id = i_inst_id[OPC_MSB:OPC_LSB];

    // Fields outside the register/opcode slices are irrelevant here.
    assign w_unused_bits = ^{i_inst_ex[31:12], i_inst_ex[6:0],
                             i_inst_id[31:25], i_inst_id[14:7]};

    assign w_rs1_hit = usesRs1(w_opc_id) && (w_rs1_id == w_rd_ex);
    assign w_rs2_hit = usesRs2(w_opc_id) && (w_rs2_id == w_rd_ex);

    // Writes to x0 are discarded, so a load into x0 creates no dependency.
    assign o_load_use = i_memread_ex && (w_rd_ex != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
// Pipeline sequencer for the 5-stage RV32I core: produces per-stage stall and
// flush controls for data-memory waits (M), taken branches (B), load-use
// hazards (L) and instruction-fetch waits (F), with priority M > B > L > F.
// Also runs a data-memory wait watchdog and two performance counters.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   inst_data_ID / inst_data_EX      instructions in ID / EX
//   memread_EX, branch_taken_EX      EX is a load / EX resolved a taken jump
//   dmem_req_MEM, dmem_ready         MEM access active / completes this cycle
//   imem_ready                       fetch delivered this cycle
//   stall_IF..stall_MEM              hold PC / IF-ID / ID-EX / EX-MEM
//   flush_ID, flush_EX, flush_WB     insert bubble into IF-ID / ID-EX / MEM-WB
//   mem_timeout                      sticky watchdog error
//   stall_cycles, flush_count        performance counters (wrap around)
// ---------------------------------------------------------------------------
module hazard_control_unit
    import core_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_data_ID,
    input  logic [31:0]      inst_data_EX,
    input  logic             memread_EX,
    input  logic             branch_taken_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             flush_ID,
    output logic             flush_EX,
    output logic             flush_WB,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [15:0] TIMEOUT_V  = 16'(TIMEOUT);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    hz_state_t        r_state;
    hz_state_t        w_next_state;
    logic [15:0]      r_wait_cnt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    logic w_load_use;
    logic w_cond_m;
    logic w_cond_b;
    logic w_cond_l;
    logic w_cond_f;
    logic w_any_stall;

    hazard_decode u_decode (
        .i_inst_id    (inst_data_ID),
        .i_inst_ex    (inst_data_EX),
        .i_memread_ex (memread_EX),
        .o_load_use   (w_load_use)
    );

    // Condition qualification implements the priority chain directly, so at
    // most one of the four is active in any cycle.
    assign w_cond_m = dmem_req_MEM && !dmem_ready;
    assign w_cond_b = branch_taken_EX && !w_cond_m;
    assign w_cond_l = w_load_use && !w_cond_m && !w_cond_b;
    assign w_cond_f = !imem_ready && !w_cond_m && !w_cond_b && !w_cond_l;

    // State register, wait counter, watchdog flag and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_wait_cnt     <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_cond_m) begin
                if (r_wait_cnt != TIMEOUT_V) begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                end
                if (r_wait_cnt == TIMEOUT_M1) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_any_stall) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_cond_b) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    // Next-state: stay in MEM_WAIT exactly as long as the data access is
    // outstanding; release happens in the same cycle dmem_ready rises.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:      if (w_cond_m)  w_next_state = MEM_WAIT;
            MEM_WAIT: if (!w_cond_m) w_next_state = RUN;
            default:  w_next_state = RUN;
        endcase
    end

    // Stall/flush outputs. Everything is forced low while reset is held so a
    // reset in the middle of a wait aborts it immediately.
    always_comb begin
        stall_IF  = 1'b0;
        stall_ID  = 1'b0;
        stall_EX  = 1'b0;
        stall_MEM = 1'b0;
        flush_ID  = 1'b0;
        flush_EX  = 1'b0;
        flush_WB  = 1'b0;
        if (!rst) begin
            if (w_cond_m) begin
                stall_IF  = 1'b1;
                stall_ID  = 1'b1;
                stall_EX  = 1'b1;
                stall_MEM = 1'b1;
                flush_WB  = 1'b1;
            end else if (w_cond_b) begin
                flush_ID  = 1'b1;
                flush_EX  = 1'b1;
            end else if (w_cond_l) begin
                stall_IF  = 1'b1;
                stall_ID  = 1'b1;
                flush_EX  = 1'b1;
            end else if (w_cond_f) begin
                stall_IF  = 1'b1;
                flush_ID  = 1'b1;
            end
        end
    end

    assign w_any_stall  = stall_IF || stall_ID || stall_EX || stall_MEM;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed bench: a table of single-cycle {inputs, expected outputs} vectors
// followed by hand-written multi-cycle sequences (load-use bubble, branch held
// behind a memory wait, watchdog, fetch wait and reset aborting a wait).
// Expected output order: {stall_IF, stall_ID, stall_EX, stall_MEM,
//                         flush_ID, flush_EX, flush_WB}.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam int TO = 8;

    localparam logic [31:0] NOP        = 32'h00000013;
    localparam logic [31:0] LW_X5      = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] LW_X0      = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD_657    = 32'h00728333; // add  x6,x5,x7
    localparam logic [31:0] ADD_675    = 32'h00538333; // add  x6,x7,x5
    localparam logic [31:0] ADD_600    = 32'h00000333; // add  x6,x0,x0
    localparam logic [31:0] LUI_X6     = 32'h00028337; // lui  x6,0x28 (rs1 field = 5)
    localparam logic [31:0] JAL_X1     = 32'h000280EF; // jal  with rs1 field = 5
    localparam logic [31:0] ADDI_5     = 32'h00500313; // addi x6,x0,5 (rs2 field = 5)
    localparam logic [31:0] SW_X5      = 32'h00512023; // sw   x5,0(x2)
    localparam logic [31:0] BEQ_X5     = 32'h00028063; // beq  x5,x0,0

    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_M    = 7'b1111001;
    localparam logic [6:0] E_B    = 7'b0000110;
    localparam logic [6:0] E_L    = 7'b1100010;
    localparam logic [6:0] E_F    = 7'b1000100;

    typedef struct {
        string       name;
        logic [31:0] idInst;
        logic [31:0] exInst;
        logic        memRd;
        logic        br;
        logic        dReq;
        logic        dRdy;
        logic        iRdy;
        logic [6:0]  expOut;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instId = NOP;
    logic [31:0] instEx = NOP;
    logic        memRd = 1'b0;
    logic        br = 1'b0;
    logic        dReq = 1'b0;
    logic        dRdy = 1'b1;
    logic        iRdy = 1'b1;

    logic        stallIf, stallId, stallEx, stallMem;
    logic        flushId, flushEx, flushWb;
    logic        memTimeout;
    logic [31:0] stallCycles;
    logic [31:0] flushCount;
    logic [6:0]  outVec;

    int nTests = 0;
    int nFail  = 0;
    vec_t vecs[$];

    hazard_control_unit #(
        .TIMEOUT (TO),
        .CNT_W   (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_data_ID    (instId),
        .inst_data_EX    (instEx),
        .memread_EX      (memRd),
        .branch_taken_EX (br),
        .dmem_req_MEM    (dReq),
        .dmem_ready      (dRdy),
        .imem_ready      (iRdy),
        .stall_IF        (stallIf),
        .stall_ID        (stallId),
        .stall_EX        (stallEx),
        .stall_MEM       (stallMem),
        .flush_ID        (flushId),
        .flush_EX        (flushEx),
        .flush_WB        (flushWb),
        .mem_timeout     (memTimeout),
        .stall_cycles    (stallCycles),
        .flush_count     (flushCount)
    );

    assign outVec = {stallIf, stallId, stallEx, stallMem, flushId, flushEx, flushWb};

    always #5 clk = ~clk;

    // Builds one table entry.
    task automatic addVec(input string n, input logic [31:0] idI, input logic [31:0] exI,
                          input logic mr, input logic b, input logic dq, input logic dr,
                          input logic ir, input logic [6:0] e);
        vec_t v;
        v.name = n; v.idInst = idI; v.exInst = exI; v.memRd = mr; v.br = b;
        v.dReq = dq; v.dRdy = dr; v.iRdy = ir; v.expOut = e;
        vecs.push_back(v);
    endtask

    // Drives a new input set just after the falling edge and lets the
    // combinational outputs settle before returning.
    task automatic applyStimulus(input logic [31:0] idI, input logic [31:0] exI,
                                 input logic mr, input logic b, input logic dq,
                                 input logic dr, input logic ir, input logic rs);
        @(negedge clk);
        instId = idI; instEx = exI; memRd = mr; br = b;
        dReq = dq; dRdy = dr; iRdy = ir; rst = rs;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic checkOutput(input string n, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic pulseReset();
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyIdle();
    endtask

    initial begin
        int expStall;
        int expFlush;

        addVec("lu_rs1",        ADD_657, LW_X5, 1, 0, 0, 1, 1, E_L);
        addVec("lu_rs2_rtype",  ADD_675, LW_X5, 1, 0, 0, 1, 1, E_L);
        addVec("lu_store_rs2",  SW_X5,   LW_X5, 1, 0, 0, 1, 1, E_L);
        addVec("lu_branch_rs1", BEQ_X5,  LW_X5, 1, 0, 0, 1, 1, E_L);
        addVec("no_lu_lui",     LUI_X6,  LW_X5, 1, 0, 0, 1, 1, E_NONE);
        addVec("no_lu_jal",     JAL_X1,  LW_X5, 1, 0, 0, 1, 1, E_NONE);
        addVec("no_lu_itype",   ADDI_5,  LW_X5, 1, 0, 0, 1, 1, E_NONE);
        addVec("no_lu_rd_x0",   ADD_600, LW_X0, 1, 0, 0, 1, 1, E_NONE);
        addVec("no_lu_noload",  ADD_657, LW_X5, 0, 0, 0, 1, 1, E_NONE);
        addVec("branch",        NOP,     NOP,   0, 1, 0, 1, 1, E_B);
        addVec("branch_over_l", ADD_657, LW_X5, 1, 1, 0, 1, 1, E_B);
        addVec("fetch_wait",    NOP,     NOP,   0, 0, 0, 1, 0, E_F);
        addVec("l_over_f",      ADD_657, LW_X5, 1, 0, 0, 1, 0, E_L);
        addVec("mem_wait",      ADD_657, LW_X5, 1, 1, 1, 0, 0, E_M);
        addVec("mem_ready",     NOP,     NOP,   0, 0, 1, 1, 1, E_NONE);
        addVec("idle",          NOP,     NOP,   0, 0, 0, 1, 1, E_NONE);

        // Reset state, including reset masking an active memory wait.
        applyStimulus(NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_masks_outputs", {25'd0, outVec}, {25'd0, E_NONE});
        applyIdle();
        checkOutput("rst_timeout", {31'd0, memTimeout}, 32'd0);
        checkOutput("rst_stall_cycles", stallCycles, 32'd0);
        checkOutput("rst_flush_count", flushCount, 32'd0);

        // Table-driven single-cycle vectors.
        expStall = 0;
        expFlush = 0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].idInst, vecs[i].exInst, vecs[i].memRd, vecs[i].br,
                          vecs[i].dReq, vecs[i].dRdy, vecs[i].iRdy, 1'b0);
            checkOutput(vecs[i].name, {25'd0, outVec}, {25'd0, vecs[i].expOut});
            if (vecs[i].expOut[6:3] != 4'd0) expStall++;
            if (vecs[i].expOut == E_B) expFlush++;
        end
        applyIdle();
        checkOutput("table_stall_cycles", stallCycles, 32'(expStall));
        checkOutput("table_flush_count", flushCount, 32'(expFlush));

        // Load-use gives exactly one bubble: next cycle the load is in MEM.
        pulseReset();
        applyStimulus(ADD_657, LW_X5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("lu_seq_bubble", {25'd0, outVec}, {25'd0, E_L});
        applyStimulus(ADD_657, NOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("lu_seq_release", {25'd0, outVec}, {25'd0, E_NONE});
        checkOutput("lu_seq_stall_cnt", stallCycles, 32'd1);

        // Single branch pulse.
        pulseReset();
        applyStimulus(NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("br_pulse", {25'd0, outVec}, {25'd0, E_B});
        checkOutput("br_count_before", flushCount, 32'd0);
        applyIdle();
        checkOutput("br_after", {25'd0, outVec}, {25'd0, E_NONE});
        checkOutput("br_count_after", flushCount, 32'd1);

        // Branch frozen behind four memory wait cycles.
        pulseReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("frozen_br_wait%0d", k), {25'd0, outVec}, {25'd0, E_M});
        end
        applyStimulus(NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("frozen_br_release", {25'd0, outVec}, {25'd0, E_B});
        checkOutput("frozen_br_stall_cnt", stallCycles, 32'd4);
        checkOutput("frozen_br_flush_cnt0", flushCount, 32'd0);
        applyIdle();
        checkOutput("frozen_br_flush_cnt1", flushCount, 32'd1);
        checkOutput("frozen_br_no_timeout", {31'd0, memTimeout}, 32'd0);

        // Watchdog: sets after the TO-th consecutive wait cycle, is sticky.
        pulseReset();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("wd_cycle%0d", k), {31'd0, memTimeout},
                        (k > TO) ? 32'd1 : 32'd0);
        end
        checkOutput("wd_still_stalling", {25'd0, outVec}, {25'd0, E_M});
        applyIdle();
        checkOutput("wd_sticky", {31'd0, memTimeout}, 32'd1);
        checkOutput("wd_released", {25'd0, outVec}, {25'd0, E_NONE});
        checkOutput("wd_stall_cnt", stallCycles, 32'd10);
        pulseReset();
        checkOutput("wd_rst_clears", {31'd0, memTimeout}, 32'd0);
        checkOutput("wd_rst_stall_cnt", stallCycles, 32'd0);
        checkOutput("wd_rst_flush_cnt", flushCount, 32'd0);

        // Wait counter restarts after a gap, so two short waits never trip.
        for (int k = 0; k < 5; k++)
            applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyIdle();
        for (int k = 0; k < 5; k++)
            applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyIdle();
        checkOutput("wd_gap_no_timeout", {31'd0, memTimeout}, 32'd0);

        // Fetch wait for two cycles, then clear.
        pulseReset();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("fetch_wait%0d", k), {25'd0, outVec}, {25'd0, E_F});
        end
        applyIdle();
        checkOutput("fetch_done", {25'd0, outVec}, {25'd0, E_NONE});
        checkOutput("fetch_stall_cnt", stallCycles, 32'd2);

        // Reset in the middle of a memory wait aborts it.
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("abort_wait_active", {25'd0, outVec}, {25'd0, E_M});
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("abort_rst_outputs", {25'd0, outVec}, {25'd0, E_NONE});
        applyIdle();
        checkOutput("abort_after_outputs", {25'd0, outVec}, {25'd0, E_NONE});
        checkOutput("abort_after_stall_cnt", stallCycles, 32'd0);
        applyStimulus(NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("abort_then_branch", {25'd0, outVec}, {25'd0, E_B});

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencer for the RV32I 5-stage core. Generates per-stage stall (register hold) and flush (bubble insert) controls.
- Detection covers load-use hazards, taken branches/jumps resolved in EX, and instruction/data memory wait states.
- Keeps a wait-timeout watchdog and performance counters.
- Sits beside the forwarding logic. Forwarding resolves ALU-to-ALU dependencies; this block resolves everything forwarding cannot.

Parameters:
- TIMEOUT, 255, consecutive data-memory wait cycles before mem_timeout is flagged (1..2^16-1).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- inst_data_ID  input  32  instruction in ID stage.
- inst_data_EX  input  32  instruction in EX stage.
- memread_EX  input  1  EX instruction is a load.
- branch_taken_EX  input  1  EX resolved a taken branch, JAL or JALR.
- dmem_req_MEM  input  1  MEM stage has an active data-memory access.
- dmem_ready  input  1  data memory completes the access this cycle.
- imem_ready  input  1  instruction memory delivers the fetch this cycle.
- stall_IF  output  1  hold PC.
- stall_ID  output  1  hold IF/ID register.
- stall_EX  output  1  hold ID/EX register.
- stall_MEM  output  1  hold EX/MEM register.
- flush_ID  output  1  load NOP into IF/ID.
- flush_EX  output  1  load NOP into ID/EX.
- flush_WB  output  1  load NOP into MEM/WB.
- mem_timeout  output  1  sticky watchdog error.
- stall_cycles  output  CNT_W  cycles with any stall_* asserted.
- flush_count  output  CNT_W  taken-branch flush events.

Behaviour:
- State machine: RUN, MEM_WAIT. The state is registered; all stall/flush outputs are combinational from the current state and inputs.
- Reset: state=RUN, wait_cnt=0, mem_timeout=0, both counters=0. While rst=1, all stall_* and flush_* outputs are 0. Reset asserted mid-stall aborts the stall and returns to RUN the next cycle.
- Condition M = dmem_req_MEM && !dmem_ready.
  - Asserts stall_IF, stall_ID, stall_EX, stall_MEM and flush_WB.
  - All other flushes are 0 (highest priority).
  - RUN goes to MEM_WAIT on M. MEM_WAIT goes to RUN on the first cycle where !M.
  - Stalls drop in the same cycle dmem_ready rises, so there is zero extra latency.
- Condition B = branch_taken_EX && !M.
  - Asserts flush_ID and flush_EX for exactly that cycle. No stalls.
  - flush_count increments by 1.
  - A branch arriving while M holds is frozen in EX and is flushed in the first cycle M releases.
- Condition L = memread_EX && rd_EX!=0 && !M && !B, and either:
  - rs1_ID==rd_EX and ID uses rs1, or
  - rs2_ID==rd_EX and ID uses rs2.
  - Field positions: rd=[11:7], rs1=[19:15], rs2=[24:20], opcode=[6:0].
  - rs1 is used unless the ID opcode is 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
  - rs2 is used only for opcodes 0110011, 0100011 and 1100011.
  - Response: assert stall_IF, stall_ID, flush_EX. This gives one bubble, after which the load is in MEM and forwarding covers the dependency.
  - B overrides L because the ID instruction is squashed anyway.
- Condition F = !imem_ready && !M && !B && !L. Asserts stall_IF and flush_ID.
- Priority order: M > B > L > F. Outputs not driven by the active condition are 0.
- Watchdog:
  - wait_cnt increments every M cycle and clears on !M. It saturates at TIMEOUT.
  - When wait_cnt==TIMEOUT-1 and M holds, mem_timeout sets on the next edge.
  - mem_timeout stays set until rst. It does not release the stall.
- Counters: stall_cycles increments when any stall_* is 1. Both counters wrap modulo 2^CNT_W.

Decomposition:
- Shared package core_pkg holds:
  - opcode localparams OP_LUI, OP_AUIPC, OP_JAL, OP_RTYPE, OP_STORE, OP_BRANCH;
  - the field-slice constants;
  - typedef enum hz_state_t {RUN, MEM_WAIT}.
- Sub-module hazard_decode (combinational): takes the ID and EX instructions plus memread_EX and produces the load_use signal. It is reusable by the bench scoreboard.

Test Plan:
- EX = lw x5,0(x1) (memread_EX=1), ID = add x6,x5,x7 → one cycle of stall_IF=stall_ID=flush_EX=1, then all 0. With ID = lui x5,1, no stall.
- EX load with rd=x0, ID = add x6,x0,x0 → no stall. EX load rd=x5, ID = sw x5,0(x2) → stall, because rs2 is used.
- branch_taken_EX=1 for 1 cycle → flush_ID=flush_EX=1 that cycle only, flush_count 0→1. Applied in the same cycle as a load-use condition, it gives flush only with no stall.
- dmem_req_MEM=1, dmem_ready=0 for 4 cycles with branch_taken_EX=1 throughout → 4 cycles of stall_IF..MEM=1 with flush_WB=1 and no flush_ID. Fifth cycle dmem_ready=1 → stalls drop, flush_ID=flush_EX=1, stall_cycles=4.
- TIMEOUT=8, hold M for 10 cycles → mem_timeout rises after the 8th wait cycle and stays 1 after release. Pulsing rst clears it and both counters.
- imem_ready=0 for 2 cycles with no other hazards → stall_IF=flush_ID=1 for 2 cycles. Asserting rst mid-wait drives all outputs to 0 that cycle, and the state is RUN afterwards.
